// File: rtl/clk_burst_ctl_pkg.sv
// Shared definitions for the clock burst controller: function codes,
// controller states, clock-source encodings and the counter width.
package clk_burst_ctl_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    F_STOP     = 3'd0,
    F_RUN      = 3'd1,
    F_STEP     = 3'd2,
    F_BURST    = 3'd3,
    F_LDCNT_LO = 3'd4,
    F_LDCNT_HI = 3'd5,
    F_LDSRC    = 3'd6,
    F_CLRERR   = 3'd7
  } func_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_BURST   = 2'd2,
    S_ERRSTOP = 2'd3
  } burst_state_t;

  typedef enum logic [1:0] {
    SRC_INT    = 2'd0,
    SRC_EXT    = 2'd1,
    SRC_SYNC   = 2'd2,
    SRC_DESKEW = 2'd3
  } src_t;

endpackage

// File: rtl/clk_burst_ctl_cnt.sv
// Working burst counter: loadable, decrements once per burst cycle.
// zero_next flags that the next decrement lands on zero, so the controller
// can leave BURST on the same edge. A load of 0 wraps through 4095..1,
// giving 4096 decrements before zero is reached.
module clk_burst_cnt
  import clk_burst_ctl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero_next
);

  // Counter register: load has priority over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec)
      count <= count - 1'b1;
  end

  assign zero_next = (count == CNT_W'(1));

endmodule

// File: rtl/clk_burst_ctl.sv
// Clock burst controller: decodes diagnostic functions into free-run,
// single-step and counted-burst clock enables, with error-stop handling
// and an EBUS readback path.
module clk_burst_ctl
  import clk_burst_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_func_l,
  input  logic [2:0] func,
  input  logic [5:0] data,
  input  logic       rd_func_l,
  input  logic       error_stop,
  output logic [1:0] src_sel,
  output logic       fs_en,
  output logic       running,
  output logic       burst_busy,
  output logic       stopped_err,
  output logic [5:0] rd_data
);

  burst_state_t     state, state_next;
  func_t            fcode;
  logic             strobe;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] work_cnt;
  logic             wk_load;
  logic [CNT_W-1:0] wk_val;
  logic             wk_dec;
  logic             zero_next;

  assign fcode  = func_t'(func);
  assign strobe = ~ld_func_l;

  // Loaded count and source select accept loads in every state; the
  // working counter is a separate copy so an active burst is unaffected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
      src_sel  <= SRC_INT;
    end else if (strobe) begin
      case (fcode)
        F_LDCNT_LO: load_cnt[5:0]  <= data;
        F_LDCNT_HI: load_cnt[11:6] <= data;
        F_LDSRC:    src_sel        <= data[1:0];
        default:    ;
      endcase
    end
  end

  // State register; async reset drops fs_en immediately via the state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state, working-counter control and state-decoded outputs.
  // error_stop is checked before STOP so it wins a same-cycle collision.
  always_comb begin
    state_next  = state;
    wk_load     = 1'b0;
    wk_val      = load_cnt;
    wk_dec      = 1'b0;
    fs_en       = 1'b0;
    running     = 1'b0;
    burst_busy  = 1'b0;
    stopped_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (strobe) begin
          case (fcode)
            F_RUN:   state_next = S_RUN;
            F_STEP: begin
              state_next = S_BURST;
              wk_load    = 1'b1;
              wk_val     = CNT_W'(1);
            end
            F_BURST: begin
              state_next = S_BURST;
              wk_load    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        fs_en   = 1'b1;
        running = 1'b1;
        if (error_stop)
          state_next = S_ERRSTOP;
        else if (strobe && fcode == F_STOP)
          state_next = S_IDLE;
      end
      S_BURST: begin
        fs_en      = 1'b1;
        burst_busy = 1'b1;
        wk_dec     = 1'b1;
        if (error_stop)
          state_next = S_ERRSTOP;
        else if (strobe && fcode == F_STOP)
          state_next = S_IDLE;
        else if (zero_next)
          state_next = S_IDLE;
      end
      S_ERRSTOP: begin
        stopped_err = 1'b1;
        if (strobe && fcode == F_CLRERR)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  clk_burst_cnt u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (wk_load),
    .load_val  (wk_val),
    .dec       (wk_dec),
    .count     (work_cnt),
    .zero_next (zero_next)
  );

  // EBUS readback mux, combinational from the read select and function code.
  always_comb begin
    rd_data = '0;
    if (!rd_func_l) begin
      case (func)
        3'd0:    rd_data = {stopped_err, burst_busy, running, 1'b0, src_sel};
        3'd1:    rd_data = work_cnt[5:0];
        3'd2:    rd_data = work_cnt[11:6];
        default: rd_data = '0;
      endcase
    end
  end

endmodule
